// File: rtl/robin_mon_pkg.sv
// Shared definitions for the robin serial monitor protocol: command codes,
// header layout, error codes and the initiator FSM state encoding.
package robin_mon_pkg;

  localparam logic [1:0] CMD_ILLEGAL = 2'd0;
  localparam logic [1:0] CMD_LOAD    = 2'd1;
  localparam logic [1:0] CMD_DUMP    = 2'd2;
  localparam logic [1:0] CMD_EXEC    = 2'd3;

  localparam int HDR_LEN = 6;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ECHO    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CMD     = 2'd3
  } err_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR_TX   = 4'd1,
    ST_HDR_ECHO = 4'd2,
    ST_LD_RD    = 4'd3,
    ST_LD_TX    = 4'd4,
    ST_LD_ECHO  = 4'd5,
    ST_DP_RX    = 4'd6,
    ST_FIN      = 4'd7,
    ST_ABORT    = 4'd8
  } state_t;

  // Header is {cmd, 0, addr hi, addr lo, len hi, len lo}, big-endian fields.
  function automatic logic [7:0] hdr_byte(input logic [1:0] c, input logic [15:0] a,
                                          input logic [15:0] l, input logic [2:0] i);
    case (i)
      3'd0:    return {6'b0, c};
      3'd1:    return 8'h00;
      3'd2:    return a[15:8];
      3'd3:    return a[7:0];
      3'd4:    return l[15:8];
      default: return l[7:0];
    endcase
  endfunction

endpackage

// File: rtl/monitor_host_if.sv
// UART byte channel and local memory port between the monitor initiator and its
// surroundings.
interface monitor_host_if #(parameter int ADDR_W = 16);
  // Byte channel: tx_start is a one-cycle strobe, legal only while tx_ready=1;
  // rx_valid is a one-cycle strobe qualifying rx_byte, with no back-pressure.
  // Memory: mem_rdata reflects mem_raddr one cycle later; mem_write is a
  // one-cycle strobe qualifying mem_waddr/mem_wdata.
  logic [7:0]        tx_byte;
  logic              tx_start;
  logic              tx_ready;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_write;

  modport master (
    output tx_byte, tx_start, mem_raddr, mem_waddr, mem_wdata, mem_write,
    input  tx_ready, rx_byte, rx_valid, mem_rdata
  );

  modport slave (
    input  tx_byte, tx_start, mem_raddr, mem_waddr, mem_wdata, mem_write,
    output tx_ready, rx_byte, rx_valid, mem_rdata
  );
endinterface

// File: rtl/mon_timeout.sv
// Loadable down-counter guarding every wait for a received byte.
module mon_timeout #(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Flags the cycle whose decrement reaches zero, so the abort lands exactly
  // TIMEOUT cycles after the load.
  assign expired = (count <= W'(1));

endmodule

// File: rtl/monitor_host.sv
// Initiator for the robin serial monitor: sends LOAD/DUMP/EXEC headers and data
// over a byte UART, checking each echo in lock-step before sending the next byte.
module monitor_host
  import robin_mon_pkg::*;
#(
  parameter int              ADDR_W  = 16,
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd1200000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [15:0]       addr,
  input  logic [15:0]       len,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output state_t            dbg_state,
  monitor_host_if.master    bus
);

  localparam logic [2:0] HDR_LAST = 3'(HDR_LEN - 1);

  state_t            state, state_n;
  logic [1:0]        cmd_q, cmd_n;
  logic [15:0]       addr_q, addr_n;
  logic [15:0]       len_q, len_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [2:0]        hdr_idx, idx_n;
  logic [ADDR_W-1:0] k_q, k_n;
  logic [15:0]       rem_q, rem_n;
  logic              error_q, error_n;
  err_t              code_q, code_n;
  logic [7:0]        tx_byte_n;
  logic              tx_start_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [7:0]        wdata_n;
  logic              mem_write_n;
  logic              tmr_load, tmr_dec, tmr_expired;

  mon_timeout #(.W(TO_W)) u_timeout (
    .CLK     (CLK),
    .reset   (reset),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .value   (TIMEOUT),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cmd_q         <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      base_q        <= '0;
      hdr_idx       <= '0;
      k_q           <= '0;
      rem_q         <= '0;
      error_q       <= 1'b0;
      code_q        <= ERR_NONE;
      bus.tx_byte   <= '0;
      bus.tx_start  <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_write <= 1'b0;
    end else begin
      state         <= state_n;
      cmd_q         <= cmd_n;
      addr_q        <= addr_n;
      len_q         <= len_n;
      base_q        <= base_n;
      hdr_idx       <= idx_n;
      k_q           <= k_n;
      rem_q         <= rem_n;
      error_q       <= error_n;
      code_q        <= code_n;
      bus.tx_byte   <= tx_byte_n;
      bus.tx_start  <= tx_start_n;
      bus.mem_waddr <= waddr_n;
      bus.mem_wdata <= wdata_n;
      bus.mem_write <= mem_write_n;
    end
  end

  always_comb begin
    state_n     = state;
    cmd_n       = cmd_q;
    addr_n      = addr_q;
    len_n       = len_q;
    base_n      = base_q;
    idx_n       = hdr_idx;
    k_n         = k_q;
    rem_n       = rem_q;
    error_n     = error_q;
    code_n      = code_q;
    tx_byte_n   = bus.tx_byte;
    tx_start_n  = 1'b0;
    waddr_n     = bus.mem_waddr;
    wdata_n     = bus.mem_wdata;
    mem_write_n = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = (state == ST_HDR_ECHO) || (state == ST_LD_ECHO) || (state == ST_DP_RX);

    case (state)
      ST_IDLE: begin
        if (start) begin
          cmd_n  = cmd;
          addr_n = addr;
          len_n  = len;
          base_n = base;
          idx_n  = '0;
          k_n    = '0;
          rem_n  = len;
          if (cmd == CMD_ILLEGAL) begin
            state_n = ST_ABORT;
            error_n = 1'b1;
            code_n  = ERR_CMD;
          end else begin
            state_n = ST_HDR_TX;
            error_n = 1'b0;
            code_n  = ERR_NONE;
          end
        end
      end
      ST_HDR_TX: begin
        if (bus.tx_ready) begin
          tx_start_n = 1'b1;
          tx_byte_n  = hdr_byte(cmd_q, addr_q, len_q, hdr_idx);
          state_n    = ST_HDR_ECHO;
        end
      end
      ST_HDR_ECHO: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte != bus.tx_byte) begin
            state_n = ST_ABORT;
            error_n = 1'b1;
            code_n  = ERR_ECHO;
          end else if (hdr_idx == HDR_LAST) begin
            case (cmd_q)
              CMD_LOAD: state_n = ST_LD_RD;
              CMD_DUMP: begin
                state_n  = ST_DP_RX;
                tmr_load = 1'b1;
              end
              CMD_EXEC: state_n = ST_FIN;
              default:  state_n = ST_FIN;
            endcase
          end else begin
            idx_n   = hdr_idx + 3'd1;
            state_n = ST_HDR_TX;
          end
        end else if (tmr_expired) begin
          state_n = ST_ABORT;
          error_n = 1'b1;
          code_n  = ERR_TIMEOUT;
        end
      end
      // mem_raddr follows base+k continuously, so mem_rdata is valid in LD_TX.
      ST_LD_RD: begin
        if (rem_q == 16'd0) state_n = ST_FIN;
        else                state_n = ST_LD_TX;
      end
      ST_LD_TX: begin
        if (bus.tx_ready) begin
          tx_start_n = 1'b1;
          tx_byte_n  = bus.mem_rdata;
          state_n    = ST_LD_ECHO;
        end
      end
      ST_LD_ECHO: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte != bus.tx_byte) begin
            state_n = ST_ABORT;
            error_n = 1'b1;
            code_n  = ERR_ECHO;
          end else begin
            k_n     = k_q + 1'b1;
            rem_n   = rem_q - 1'b1;
            state_n = ST_LD_RD;
          end
        end else if (tmr_expired) begin
          state_n = ST_ABORT;
          error_n = 1'b1;
          code_n  = ERR_TIMEOUT;
        end
      end
      ST_DP_RX: begin
        if (rem_q == 16'd0) begin
          state_n = ST_FIN;
        end else if (bus.rx_valid) begin
          waddr_n     = base_q + k_q;
          wdata_n     = bus.rx_byte;
          mem_write_n = 1'b1;
          k_n         = k_q + 1'b1;
          rem_n       = rem_q - 1'b1;
          tmr_load    = 1'b1;
        end else if (tmr_expired) begin
          state_n = ST_ABORT;
          error_n = 1'b1;
          code_n  = ERR_TIMEOUT;
        end
      end
      ST_FIN:   state_n = ST_IDLE;
      ST_ABORT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    if (tx_start_n) tmr_load = 1'b1;
  end

  assign bus.mem_raddr = base_q + k_q;
  assign busy          = !((state == ST_IDLE) || (state == ST_FIN) || (state == ST_ABORT));
  assign done          = (state == ST_FIN) || (state == ST_ABORT);
  assign error         = error_q;
  assign err_code      = code_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_monitor_host.sv
// Directed bench for monitor_host: table of complete transactions against an
// echoing UART model and a 1-cycle-latency memory, plus reset and stall sequences.
module tb_monitor_host;
  import robin_mon_pkg::*;

  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [1:0]    cmd;
  logic [15:0]   addr, len;
  logic [AW-1:0] base;
  logic          busy, done, error;
  logic [1:0]    err_code;
  state_t        dbg_state;

  monitor_host_if #(.ADDR_W(AW)) bus ();

  monitor_host #(.ADDR_W(AW), .TO_W(24), .TIMEOUT(24'd100)) dut (
    .CLK       (clk),
    .reset     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .addr      (addr),
    .len       (len),
    .base      (base),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .dbg_state (dbg_state),
    .bus       (bus.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [7:0] rom  [0:65535];
  logic [7:0] wmem [0:65535];
  always @(posedge clk) begin
    bus.mem_rdata <= rom[bus.mem_raddr];
    if (bus.mem_write) wmem[bus.mem_waddr] <= bus.mem_wdata;
  end

  // ---------------- UART model ----------------
  // mode 0: echo; 1: corrupt echo of tx number m_bad; 2: silent after first echo;
  // 3: echo header then stream m_pay.
  int          run_id = 0, seen_id = 0;
  int          m_mode = 0, m_bad = 0, m_npay = 0;
  logic [31:0] m_pay = '0;
  int          n_tx_seen = 0, n_echo = 0, pend_cnt = 0, pay_i = 0, gap = 2, wr_cnt = 0;
  int          first_tx_cyc = 0, last_tx_cyc = 0;
  logic [7:0]  pend_byte = '0;
  logic [7:0]  tx_seen [0:15];

  always @(negedge clk) begin
    bus.rx_valid = 1'b0;
    if (run_id != seen_id) begin
      seen_id = run_id; n_tx_seen = 0; n_echo = 0; pend_cnt = 0;
      pay_i = 0; gap = 2; wr_cnt = 0; first_tx_cyc = 0; last_tx_cyc = 0;
    end
    if (bus.mem_write) wr_cnt++;
    if (bus.tx_start) begin
      if (n_tx_seen < 16) tx_seen[n_tx_seen] = bus.tx_byte;
      if (n_tx_seen == 0) first_tx_cyc = cyc;
      last_tx_cyc = cyc;
      n_tx_seen++;
      if (!(m_mode == 2 && n_tx_seen > 1)) begin
        pend_byte = (m_mode == 1 && n_tx_seen == m_bad) ? 8'h02 : bus.tx_byte;
        pend_cnt  = 3;
      end
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = pend_byte;
        n_echo++;
      end
    end else if (m_mode == 3 && n_echo >= 6 && pay_i < m_npay) begin
      if (gap == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = m_pay[31-8*pay_i -: 8];
        pay_i++;
        gap = 3;
      end else begin
        gap--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic arm(input int mode, input int bad, input int npay, input logic [31:0] pay);
    m_mode = mode; m_bad = bad; m_npay = npay; m_pay = pay;
    run_id++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_start(input logic [1:0] c, input logic [15:0] a, input logic [15:0] l,
                            input logic [AW-1:0] b, output int s);
    start = 1'b1; cmd = c; addr = a; len = l; base = b;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dc);
    ok = 1'b0; dc = 0;
    for (int t = 0; t < budget; t++) begin
      if (done === 1'b1) begin
        ok = 1'b1; dc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]    cmd;
    logic [15:0]   addr;
    logic [15:0]   len;
    logic [AW-1:0] base;
    int            mode;
    int            bad;
    int            n_tx;
    logic [71:0]   tx;
    logic          err;
    logic [1:0]    code;
    int            lat;
    int            n_wr;
    logic [31:0]   pay;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] c, input logic [15:0] a, input logic [15:0] l,
                              input logic [AW-1:0] b, input int mode, input int bad,
                              input int n_tx, input logic [71:0] tx, input logic e,
                              input logic [1:0] code, input int lat, input int n_wr,
                              input logic [31:0] pay);
    vec_t v;
    v.cmd = c; v.addr = a; v.len = l; v.base = b; v.mode = mode; v.bad = bad;
    v.n_tx = n_tx; v.tx = tx; v.err = e; v.code = code; v.lat = lat;
    v.n_wr = n_wr; v.pay = pay;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int s, dc;
    bit ok;
    logic [7:0] e;
    arm(v.mode, v.bad, v.n_wr, v.pay);
    for (int i = 0; i < v.n_tx; i++) exp_q.push_back(v.tx[71-8*i -: 8]);
    send_start(v.cmd, v.addr, v.len, v.base, s);
    if (v.cmd != CMD_ILLEGAL) chk($sformatf("v%0d_busy", n), busy, 1);
    wait_done(3000, ok, dc);
    chk($sformatf("v%0d_done_seen", n), ok, 1);
    chk($sformatf("v%0d_error", n), error, v.err);
    chk($sformatf("v%0d_err_code", n), err_code, v.code);
    chk($sformatf("v%0d_busy_at_done", n), busy, 0);
    chk($sformatf("v%0d_tx_count", n), n_tx_seen, v.n_tx);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_tx%0d", n, i), tx_seen[i], e);
    end
    if (v.n_tx > 0) chk($sformatf("v%0d_first_tx_lat", n), first_tx_cyc - s, 2);
    else            chk($sformatf("v%0d_done_lat", n), dc - s, 1);
    if (v.lat >= 0) chk($sformatf("v%0d_timeout_lat", n), dc - last_tx_cyc, v.lat);
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", n), done, 0);
    chk($sformatf("v%0d_error_sticky", n), error, v.err);
    repeat (4) @(negedge clk);
    chk($sformatf("v%0d_write_count", n), wr_cnt, v.n_wr);
    for (int i = 0; i < v.n_wr; i++)
      chk($sformatf("v%0d_wmem%0d", n, i), wmem[16'(v.base + i)], v.pay[31-8*i -: 8]);
  endtask

  // ---------------- test ----------------
  vec_t vecs [0:7];

  initial begin
    int  s, dc, dcount;
    bit  ok;

    vecs[0] = mk(CMD_LOAD,    16'h0200, 16'd3, 16'h0010, 0, 0, 9, 72'h01_00_02_00_00_03_A5_5A_FF, 1'b0, 2'd0, -1, 0, 32'h0);
    vecs[1] = mk(CMD_DUMP,    16'h0000, 16'd4, 16'h0040, 3, 0, 6, 72'h02_00_00_00_00_04_00_00_00, 1'b0, 2'd0, -1, 4, 32'h11223344);
    vecs[2] = mk(CMD_ILLEGAL, 16'h5555, 16'd7, 16'h0000, 0, 0, 0, 72'h0,                          1'b1, 2'd3, -1, 0, 32'h0);
    vecs[3] = mk(CMD_EXEC,    16'h2000, 16'd0, 16'h0000, 0, 0, 6, 72'h03_00_20_00_00_00_00_00_00, 1'b0, 2'd0, -1, 0, 32'h0);
    vecs[4] = mk(CMD_LOAD,    16'h0200, 16'd3, 16'h0010, 1, 4, 4, 72'h01_00_02_00_00_00_00_00_00, 1'b1, 2'd1, -1, 0, 32'h0);
    vecs[5] = mk(CMD_EXEC,    16'h1234, 16'd5, 16'h0000, 2, 0, 2, 72'h03_00_00_00_00_00_00_00_00, 1'b1, 2'd2, 100, 0, 32'h0);
    vecs[6] = mk(CMD_LOAD,    16'hABCD, 16'd0, 16'h0010, 0, 0, 6, 72'h01_00_AB_CD_00_00_00_00_00, 1'b0, 2'd0, -1, 0, 32'h0);
    vecs[7] = mk(CMD_LOAD,    16'h0010, 16'd2, 16'hFFFF, 0, 0, 8, 72'h01_00_00_10_00_02_77_88_00, 1'b0, 2'd0, -1, 0, 32'h0);

    rom[16'h0010] = 8'hA5; rom[16'h0011] = 8'h5A; rom[16'h0012] = 8'hFF;
    rom[16'hFFFF] = 8'h77; rom[16'h0000] = 8'h88;
    for (int i = 0; i < 5; i++) rom[16'h0020 + i] = 8'(8'hC0 + i);

    rst_n = 1'b0; start = 1'b0; cmd = '0; addr = '0; len = '0; base = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_raddr", bus.mem_raddr, 0);
    chk("rst_mem_waddr", bus.mem_waddr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 8; n++) run_vec(vecs[n], n);

    // Transmitter held busy: header waits in HDR_TX; a start while busy is ignored.
    arm(0, 0, 0, 32'h0);
    bus.tx_ready = 1'b0;
    send_start(CMD_EXEC, 16'h0001, 16'h0000, 16'h0000, s);
    repeat (5) @(negedge clk);
    chk("stall_no_tx", n_tx_seen, 0);
    chk("stall_state", dbg_state, ST_HDR_TX);
    start = 1'b1; cmd = CMD_ILLEGAL;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored_state", dbg_state, ST_HDR_TX);
    chk("busy_start_ignored_error", error, 0);
    bus.tx_ready = 1'b1;
    wait_done(3000, ok, dc);
    chk("stall_done_seen", ok, 1);
    chk("stall_error", error, 0);
    chk("stall_tx_count", n_tx_seen, 6);
    chk("stall_tx0", tx_seen[0], 8'h03);
    chk("stall_tx3", tx_seen[3], 8'h01);
    repeat (3) @(negedge clk);

    // Reset in the middle of a LOAD payload, then an illegal command.
    arm(0, 0, 0, 32'h0);
    send_start(CMD_LOAD, 16'h0300, 16'd5, 16'h0020, s);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (n_tx_seen >= 8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("midload_reached", ok, 1);
    chk("midload_byte2", tx_seen[7], 8'hC1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    dcount = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    chk("midrst_no_tx", n_tx_seen, 8);
    send_start(CMD_ILLEGAL, 16'h0000, 16'h0000, 16'h0000, s);
    chk("illegal_done", done, 1);
    chk("illegal_error", error, 1);
    chk("illegal_code", err_code, 3);
    chk("illegal_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("illegal_no_tx", n_tx_seen, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
